// File: rtl/infifo_dispatch_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// infifo_dispatch_arbiter_pkg
// Shared definitions for the input-FIFO packet dispatcher:
//   state_e        : dispatcher FSM states (ST_IDLE, ST_FORWARD)
//   rr_next_index  : next round-robin thread index, wrapping at a thread count
//                    that need not be a power of two
// -----------------------------------------------------------------------------
package infifo_dispatch_arbiter_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_FORWARD = 1'b1
    } state_e;

    // The wrap is done by comparison rather than by masking, so thread counts
    // such as 5 or 6 never produce an index outside 0..num-1.
    function automatic int unsigned rr_next_index(input int unsigned idx,
                                                  input int unsigned num);
        return (idx + 32'd1 >= num) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/infifo_dispatch_arbiter_rr_index_counter.sv
// -----------------------------------------------------------------------------
// infifo_dispatch_arbiter_rr_index_counter
// SEL_WIDTH-bit counter modulo NUM_THREADS. Used as the thread selector of the
// dispatcher; written generically so the output-FIFO side can reuse it.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (index returns to 0)
//   advance     : step to the next index, wrapping at NUM_THREADS
//   load        : take load_value instead (has priority over advance);
//                 values >= NUM_THREADS are replaced by 0
//   load_value  : index to load
//   index       : registered current index
// -----------------------------------------------------------------------------
module infifo_dispatch_arbiter_rr_index_counter
    import infifo_dispatch_arbiter_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 8,
    parameter int unsigned SEL_WIDTH   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 advance,
    input  logic                 load,
    input  logic [SEL_WIDTH-1:0] load_value,
    output logic [SEL_WIDTH-1:0] index
);

    logic [SEL_WIDTH-1:0] index_q;
    logic [SEL_WIDTH-1:0] index_d;

    // Next index: an out-of-range load is clamped to thread 0 so the register
    // can only ever hold a valid thread number.
    always_comb begin
        index_d = index_q;
        if (load) begin
            if (32'(load_value) < NUM_THREADS) begin
                index_d = load_value;
            end else begin
                index_d = '0;
            end
        end else if (advance) begin
            index_d = SEL_WIDTH'(rr_next_index(32'(index_q), NUM_THREADS));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    assign index = index_q;

endmodule

// File: rtl/infifo_dispatch_arbiter.sv
// -----------------------------------------------------------------------------
// infifo_dispatch_arbiter
// Routes whole packets from the shared small input FIFO to one of NUM_THREADS
// per-thread FIFOs, then pulses the CPU enable of the thread that received the
// completed packet.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   firstword_in         : word is first of a packet (qualified by fifowrite_in)
//   lastword_in          : word is last of a packet (qualified by fifowrite_in)
//   fifowrite_in         : a word is presented by the small FIFO this cycle
//   thread_sel_in        : forced target thread, used only when RR_MODE = 0
//   thread_busy          : per-thread FIFO cannot take a new packet
//   firstword_out        : one-hot firstword to the selected thread
//   fifowrite_out        : one-hot write strobe to the selected thread
//   enable_cpu_out       : one-cycle pulse, packet complete for that thread
//   stop_smallfifo_read  : hold the small FIFO read
//   cur_thread           : registered selected thread
//   pkt_count            : packets dispatched, wrapping
//   proto_err            : sticky framing error, cleared only by reset
// -----------------------------------------------------------------------------
module infifo_dispatch_arbiter
    import infifo_dispatch_arbiter_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 8,
    parameter int unsigned SEL_WIDTH   = 3,
    parameter int unsigned RR_MODE     = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   firstword_in,
    input  logic                   lastword_in,
    input  logic                   fifowrite_in,
    input  logic [SEL_WIDTH-1:0]   thread_sel_in,
    input  logic [NUM_THREADS-1:0] thread_busy,
    output logic [NUM_THREADS-1:0] firstword_out,
    output logic [NUM_THREADS-1:0] fifowrite_out,
    output logic [NUM_THREADS-1:0] enable_cpu_out,
    output logic                   stop_smallfifo_read,
    output logic [SEL_WIDTH-1:0]   cur_thread,
    output logic [CNT_WIDTH-1:0]   pkt_count,
    output logic                   proto_err
);

    state_e                 state_q;
    state_e                 state_d;
    logic [NUM_THREADS-1:0] enable_q;
    logic [NUM_THREADS-1:0] enable_d;
    logic [CNT_WIDTH-1:0]   pkt_count_q;
    logic [CNT_WIDTH-1:0]   pkt_count_d;
    logic                   proto_err_q;
    logic                   proto_err_d;

    logic [SEL_WIDTH-1:0]   sel;
    logic [NUM_THREADS-1:0] sel_hot;
    logic                   sel_busy;
    logic                   rr_advance;
    logic                   rr_load;
    logic                   write_en;
    logic                   first_en;
    logic                   stop_raw;
    logic                   pkt_end;

    infifo_dispatch_arbiter_rr_index_counter #(
        .NUM_THREADS (NUM_THREADS),
        .SEL_WIDTH   (SEL_WIDTH)
    ) u_rr_index_counter (
        .clk        (clk),
        .reset      (reset),
        .advance    (rr_advance),
        .load       (rr_load),
        .load_value (thread_sel_in),
        .index      (sel)
    );

    // One-hot decode of the selected thread; also used to pick its busy bit
    // without indexing thread_busy by a possibly wider select value.
    for (genvar i = 0; i < NUM_THREADS; i++) begin : g_decode
        assign sel_hot[i] = (sel == SEL_WIDTH'(i));
    end

    assign sel_busy = |(sel_hot & thread_busy);

    // FSM next state and datapath controls. A single-word packet (first and
    // last together) completes in IDLE without visiting FORWARD. A firstword
    // inside FORWARD restarts the packet on the same thread; the abandoned
    // packet never produces an enable pulse.
    always_comb begin
        state_d     = state_q;
        enable_d    = '0;
        pkt_count_d = pkt_count_q;
        proto_err_d = proto_err_q;
        rr_advance  = 1'b0;
        rr_load     = 1'b0;
        write_en    = 1'b0;
        first_en    = 1'b0;
        stop_raw    = 1'b0;
        pkt_end     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stop_raw = sel_busy;
                if (fifowrite_in && !firstword_in) begin
                    proto_err_d = 1'b1;
                end else if (fifowrite_in && firstword_in && !sel_busy) begin
                    write_en = 1'b1;
                    first_en = 1'b1;
                    if (lastword_in) begin
                        pkt_end = 1'b1;
                    end else begin
                        state_d = ST_FORWARD;
                    end
                end
                // A forced selection must not move under a packet that has
                // just started, so loading stops once FORWARD is entered.
                if (RR_MODE != 0) begin
                    rr_advance = sel_busy || pkt_end;
                end else begin
                    rr_load = (state_d == ST_IDLE);
                end
            end

            ST_FORWARD: begin
                write_en = fifowrite_in;
                if (fifowrite_in && firstword_in) begin
                    proto_err_d = 1'b1;
                    first_en    = 1'b1;
                end
                if (fifowrite_in && lastword_in) begin
                    pkt_end = 1'b1;
                end
                if (pkt_end) begin
                    state_d    = ST_IDLE;
                    rr_advance = (RR_MODE != 0);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pkt_end) begin
            enable_d    = sel_hot;
            pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            enable_q    <= '0;
            pkt_count_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            pkt_count_q <= pkt_count_d;
            proto_err_q <= proto_err_d;
        end
    end

    // The combinational outputs are forced to their idle values while reset is
    // high, so no write leaks out and the small FIFO is held during reset.
    always_comb begin
        firstword_out       = '0;
        fifowrite_out       = '0;
        stop_smallfifo_read = 1'b1;
        if (!reset) begin
            stop_smallfifo_read = stop_raw;
            if (write_en) begin
                fifowrite_out = sel_hot;
            end
            if (first_en) begin
                firstword_out = sel_hot;
            end
        end
    end

    assign enable_cpu_out = enable_q;
    assign cur_thread     = sel;
    assign pkt_count      = pkt_count_q;
    assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_infifo_dispatch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_infifo_dispatch_arbiter
// Three dispatcher instances share one stimulus stream:
//   u0 : 8 threads, round-robin
//   u1 : 5 threads, round-robin (non-power-of-two wrap)
//   u2 : 8 threads, forced selection, 4-bit select (out-of-range values)
// A packet-level model tracks each instance and is compared every cycle;
// directed literal checks pin the model to hand-worked values.
// -----------------------------------------------------------------------------
module tb_infifo_dispatch_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       fw;
    logic       first;
    logic       last;
    logic [7:0] busy;
    logic [3:0] tsel;

    logic [7:0]  fwo8, fo8, en8;
    logic        stop8, err8;
    logic [2:0]  cur8;
    logic [15:0] cnt8;

    logic [4:0]  fwo5, fo5, en5;
    logic        stop5, err5;
    logic [2:0]  cur5;
    logic [15:0] cnt5;

    logic [7:0]  fwom, fom, enm;
    logic        stopm, errm;
    logic [3:0]  curm;
    logic [15:0] cntm;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    infifo_dispatch_arbiter #(.NUM_THREADS(8), .SEL_WIDTH(3), .RR_MODE(1), .CNT_WIDTH(16)) u0 (
        .clk(clk), .reset(reset), .firstword_in(first), .lastword_in(last),
        .fifowrite_in(fw), .thread_sel_in(tsel[2:0]), .thread_busy(busy),
        .firstword_out(fo8), .fifowrite_out(fwo8), .enable_cpu_out(en8),
        .stop_smallfifo_read(stop8), .cur_thread(cur8), .pkt_count(cnt8),
        .proto_err(err8)
    );

    infifo_dispatch_arbiter #(.NUM_THREADS(5), .SEL_WIDTH(3), .RR_MODE(1), .CNT_WIDTH(16)) u1 (
        .clk(clk), .reset(reset), .firstword_in(first), .lastword_in(last),
        .fifowrite_in(fw), .thread_sel_in(tsel[2:0]), .thread_busy(busy[4:0]),
        .firstword_out(fo5), .fifowrite_out(fwo5), .enable_cpu_out(en5),
        .stop_smallfifo_read(stop5), .cur_thread(cur5), .pkt_count(cnt5),
        .proto_err(err5)
    );

    infifo_dispatch_arbiter #(.NUM_THREADS(8), .SEL_WIDTH(4), .RR_MODE(0), .CNT_WIDTH(16)) u2 (
        .clk(clk), .reset(reset), .firstword_in(first), .lastword_in(last),
        .fifowrite_in(fw), .thread_sel_in(tsel), .thread_busy(busy),
        .firstword_out(fom), .fifowrite_out(fwom), .enable_cpu_out(enm),
        .stop_smallfifo_read(stopm), .cur_thread(curm), .pkt_count(cntm),
        .proto_err(errm)
    );

    // Uniform 32-bit views of each instance's outputs for the model compare.
    logic [31:0] a_fwo [3];
    logic [31:0] a_fo  [3];
    logic [31:0] a_en  [3];
    logic [31:0] a_stop[3];
    logic [31:0] a_cur [3];
    logic [31:0] a_cnt [3];
    logic [31:0] a_err [3];

    assign a_fwo[0] = 32'(fwo8);  assign a_fwo[1] = 32'(fwo5);  assign a_fwo[2] = 32'(fwom);
    assign a_fo[0]  = 32'(fo8);   assign a_fo[1]  = 32'(fo5);   assign a_fo[2]  = 32'(fom);
    assign a_en[0]  = 32'(en8);   assign a_en[1]  = 32'(en5);   assign a_en[2]  = 32'(enm);
    assign a_stop[0] = 32'(stop8); assign a_stop[1] = 32'(stop5); assign a_stop[2] = 32'(stopm);
    assign a_cur[0] = 32'(cur8);  assign a_cur[1] = 32'(cur5);  assign a_cur[2] = 32'(curm);
    assign a_cnt[0] = 32'(cnt8);  assign a_cnt[1] = 32'(cnt5);  assign a_cnt[2] = 32'(cntm);
    assign a_err[0] = 32'(err8);  assign a_err[1] = 32'(err5);  assign a_err[2] = 32'(errm);

    // Model configuration and packet-level state per instance.
    int mn [3]  = '{8, 5, 8};
    bit mrr[3]  = '{1'b1, 1'b1, 1'b0};
    int m_sel [3] = '{0, 0, 0};
    bit m_inpkt[3] = '{1'b0, 1'b0, 1'b0};
    int m_pkts[3] = '{0, 0, 0};
    bit m_err [3] = '{1'b0, 1'b0, 1'b0};
    int m_pend[3] = '{-1, -1, -1};

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait so the
    // caller samples settled outputs well before the next edge.
    task automatic applyStimulus(input bit r, input bit w, input bit f, input bit l,
                                 input logic [7:0] bz, input logic [3:0] ts);
        @(posedge clk);
        #1;
        reset = r;
        fw    = w;
        first = f;
        last  = l;
        busy  = bz;
        tsel  = ts;
        #3;
    endtask

    // Every falling edge: compare each instance against the model, then move
    // the model to the state it will hold after the coming rising edge.
    int          s;
    bit          b;
    bit          done;
    logic [31:0] e_fwo, e_fo, e_stop, e_en;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            s = m_sel[k];
            b = busy[s];
            if (reset) begin
                e_stop = 32'd1;
                e_fwo  = 32'd0;
                e_fo   = 32'd0;
            end else if (!m_inpkt[k]) begin
                e_stop = 32'(b);
                e_fwo  = (fw && first && !b) ? (32'd1 << s) : 32'd0;
                e_fo   = e_fwo;
            end else begin
                e_stop = 32'd0;
                e_fwo  = fw ? (32'd1 << s) : 32'd0;
                e_fo   = (fw && first) ? (32'd1 << s) : 32'd0;
            end
            e_en = (m_pend[k] < 0) ? 32'd0 : (32'd1 << m_pend[k]);

            checkOutput($sformatf("u%0d.fifowrite_out", k), a_fwo[k], e_fwo);
            checkOutput($sformatf("u%0d.firstword_out", k), a_fo[k], e_fo);
            checkOutput($sformatf("u%0d.stop_smallfifo_read", k), a_stop[k], e_stop);
            checkOutput($sformatf("u%0d.enable_cpu_out", k), a_en[k], e_en);
            checkOutput($sformatf("u%0d.cur_thread", k), a_cur[k], 32'(m_sel[k]));
            checkOutput($sformatf("u%0d.pkt_count", k), a_cnt[k], 32'(m_pkts[k]) & 32'hFFFF);
            checkOutput($sformatf("u%0d.proto_err", k), a_err[k], 32'(m_err[k]));

            if (reset) begin
                m_sel[k]   = 0;
                m_inpkt[k] = 1'b0;
                m_pkts[k]  = 0;
                m_err[k]   = 1'b0;
                m_pend[k]  = -1;
            end else begin
                done      = 1'b0;
                m_pend[k] = -1;
                if (!m_inpkt[k]) begin
                    if (fw && !first) begin
                        m_err[k] = 1'b1;
                    end else if (fw && first && !b) begin
                        if (last) done = 1'b1;
                        else      m_inpkt[k] = 1'b1;
                    end
                    if (mrr[k]) begin
                        if (done || b) m_sel[k] = (s + 1) % mn[k];
                    end else if (!m_inpkt[k]) begin
                        m_sel[k] = (int'(tsel) < mn[k]) ? int'(tsel) : 0;
                    end
                end else begin
                    if (fw && first) m_err[k] = 1'b1;
                    if (fw && last)  done = 1'b1;
                    if (done) begin
                        m_inpkt[k] = 1'b0;
                        if (mrr[k]) m_sel[k] = (s + 1) % mn[k];
                    end
                end
                if (done) begin
                    m_pend[k] = s;
                    m_pkts[k]++;
                end
            end
        end
    end

    logic [4:0] exp5 [6] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01};

    initial begin
        bit found;
        reset = 1'b1;
        fw    = 1'b0;
        first = 1'b0;
        last  = 1'b0;
        busy  = 8'h00;
        tsel  = 4'h0;

        // Reset cycle and reset state
        applyStimulus(1, 0, 0, 0, 8'h00, 4'h0);
        checkOutput("reset.stop", 32'(stop8), 32'd1);
        checkOutput("reset.fwo", 32'(fwo8), 32'd0);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0);
        checkOutput("reset.cur", 32'(cur8), 32'd0);
        checkOutput("reset.cnt", 32'(cnt8), 32'd0);
        checkOutput("reset.err", 32'(err8), 32'd0);
        checkOutput("reset.en", 32'(en8), 32'd0);
        checkOutput("reset.stop_after", 32'(stop8), 32'd0);

        // Three-word packet to thread 0
        applyStimulus(0, 1, 1, 0, 8'h00, 4'h0);
        checkOutput("pkt3.w0.fwo", 32'(fwo8), 32'h01);
        checkOutput("pkt3.w0.fo", 32'(fo8), 32'h01);
        applyStimulus(0, 1, 0, 0, 8'h00, 4'h0);
        checkOutput("pkt3.w1.fwo", 32'(fwo8), 32'h01);
        checkOutput("pkt3.w1.fo", 32'(fo8), 32'h00);
        applyStimulus(0, 1, 0, 1, 8'h00, 4'h0);
        checkOutput("pkt3.w2.fwo", 32'(fwo8), 32'h01);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0);
        checkOutput("pkt3.en", 32'(en8), 32'h01);
        checkOutput("pkt3.cur", 32'(cur8), 32'd1);
        checkOutput("pkt3.cnt", 32'(cnt8), 32'd1);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0);
        checkOutput("pkt3.en_once", 32'(en8), 32'h00);

        // Busy threads 1 and 2 are skipped
        applyStimulus(0, 0, 0, 0, 8'h06, 4'h0);
        checkOutput("skip.stop1", 32'(stop8), 32'd1);
        checkOutput("skip.cur1", 32'(cur8), 32'd1);
        applyStimulus(0, 0, 0, 0, 8'h06, 4'h0);
        checkOutput("skip.stop2", 32'(stop8), 32'd1);
        checkOutput("skip.cur2", 32'(cur8), 32'd2);
        applyStimulus(0, 1, 1, 1, 8'h06, 4'h0);
        checkOutput("skip.stop3", 32'(stop8), 32'd0);
        checkOutput("skip.cur3", 32'(cur8), 32'd3);
        checkOutput("skip.fwo", 32'(fwo8), 32'h08);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0);
        checkOutput("skip.en", 32'(en8), 32'h08);
        checkOutput("skip.cnt", 32'(cnt8), 32'd2);

        // All threads busy, then only thread 5 frees up
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 0, 8'hFF, 4'h0);
            checkOutput("allbusy.stop", 32'(stop8), 32'd1);
            checkOutput("allbusy.fwo", 32'(fwo8), 32'd0);
        end
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            applyStimulus(0, 0, 0, 0, 8'hDF, 4'h0);
            if (stop8 == 1'b0) found = 1'b1;
        end
        checkOutput("free5.found", 32'(found), 32'd1);
        checkOutput("free5.cur", 32'(cur8), 32'd5);
        applyStimulus(0, 1, 1, 0, 8'hDF, 4'h0);
        checkOutput("free5.fwo", 32'(fwo8), 32'h20);
        checkOutput("free5.fo", 32'(fo8), 32'h20);
        applyStimulus(0, 1, 0, 1, 8'hDF, 4'h0);
        checkOutput("free5.fwo_last", 32'(fwo8), 32'h20);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0);
        checkOutput("free5.en", 32'(en8), 32'h20);

        // Five threads: six single-word packets wrap 4 -> 0
        applyStimulus(1, 0, 0, 0, 8'h00, 4'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 1, 1, 8'h00, 4'h0);
            checkOutput($sformatf("n5.fwo%0d", i), 32'(fwo5), 32'(exp5[i]));
            if (i > 0) checkOutput($sformatf("n5.en%0d", i - 1), 32'(en5), 32'(exp5[i - 1]));
        end
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0);
        checkOutput("n5.en5", 32'(en5), 32'h01);
        checkOutput("n5.cnt", 32'(cnt5), 32'd6);
        checkOutput("n5.cur", 32'(cur5), 32'd1);

        // Forced selection: 6, then out-of-range 9 maps to 0
        applyStimulus(0, 0, 0, 0, 8'h00, 4'd6);
        applyStimulus(0, 1, 1, 0, 8'h00, 4'd6);
        checkOutput("forced6.cur", 32'(curm), 32'd6);
        checkOutput("forced6.fwo", 32'(fwom), 32'h40);
        checkOutput("forced6.fo", 32'(fom), 32'h40);
        applyStimulus(0, 1, 0, 1, 8'h00, 4'd9);
        checkOutput("forced6.fwo_last", 32'(fwom), 32'h40);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'd9);
        checkOutput("forced6.en", 32'(enm), 32'h40);
        applyStimulus(0, 1, 1, 1, 8'h00, 4'd9);
        checkOutput("forced9.cur", 32'(curm), 32'd0);
        checkOutput("forced9.fwo", 32'(fwom), 32'h01);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'd0);
        checkOutput("forced9.en", 32'(enm), 32'h01);

        // Firstword mid-packet on thread 2, then reset mid-packet
        applyStimulus(1, 0, 0, 0, 8'h00, 4'h0);
        applyStimulus(0, 1, 1, 1, 8'h00, 4'h0);
        applyStimulus(0, 1, 1, 1, 8'h00, 4'h0);
        applyStimulus(0, 1, 1, 0, 8'h00, 4'h0);
        checkOutput("restart.w0.fwo", 32'(fwo8), 32'h04);
        applyStimulus(0, 1, 0, 0, 8'h00, 4'h0);
        applyStimulus(0, 1, 1, 0, 8'h00, 4'h0);
        checkOutput("restart.fo", 32'(fo8), 32'h04);
        checkOutput("restart.fwo", 32'(fwo8), 32'h04);
        applyStimulus(0, 1, 0, 0, 8'h00, 4'h0);
        checkOutput("restart.err", 32'(err8), 32'd1);
        checkOutput("restart.no_en", 32'(en8), 32'h00);
        checkOutput("restart.fwo_next", 32'(fwo8), 32'h04);
        applyStimulus(1, 1, 0, 0, 8'h00, 4'h0);
        checkOutput("midreset.stop", 32'(stop8), 32'd1);
        checkOutput("midreset.fwo", 32'(fwo8), 32'h00);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0);
        checkOutput("midreset.cur", 32'(cur8), 32'd0);
        checkOutput("midreset.err", 32'(err8), 32'd0);
        checkOutput("midreset.en", 32'(en8), 32'h00);
        checkOutput("midreset.cnt", 32'(cnt8), 32'd0);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0);
        checkOutput("midreset.en_after", 32'(en8), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
